serial_deserializer: RTL and testbench

- Serial-in/parallel-out receiver; the receive end of the LSB-first serial stream produced by the team's right-shifting parallel-load shift registers.
- Assembles SIZE-bit words from a bit-strobed serial input and presents each completed word in a holding register with a valid/acknowledge handshake.
- Flags overrun when the consumer is too slow.
- Sits between a serial link or bit-banged peripheral and the parallel datapath/control FSMs.

---
 rtl/serial_deserializer.sv | 147 ++++++++++++++
 tb/tb_serial_deserializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// LSB-first serial-in/parallel-out receiver with a valid/ack holding register and sticky overrun/parity flags.
// Optional parity bit after each word is compiled in with `define DESERIALIZER_PARITY_EN.
module serial_deserializer #(
   parameter int SIZE       = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       Sync,
   input  logic                       Shift_En,
   input  logic                       Shift_In,
   input  logic                       Data_Ack,
   input  logic                       Clr_Err,
   output logic [SIZE-1:0]            Data_Out,
   output logic                       Data_Valid,
   output logic                       Overrun,
   output logic                       Parity_Err,
   output logic [$clog2(SIZE+1)-1:0]  Bit_Count,
   output logic                       Busy
);

   localparam int            CW   = $clog2(SIZE+1);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

`ifdef DESERIALIZER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_PARITY} state_t;
`else
   localparam bit PAR_EN = 1'b0;
   typedef enum logic [1:0] {S_IDLE, S_RECV} state_t;
`endif

   // Handshake: Data_Valid marks an unconsumed word in Data_Out; the word is
   // consumed on the rising edge where Data_Valid && Data_Ack, and Data_Out
   // never changes while Data_Valid is high unless that same edge consumes it.

   state_t          state_q, state_d;
   logic [SIZE-1:0] sr_q, sr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            word_done;
   logic [SIZE-1:0] word;
   logic            par_check;
   logic            load;
   logic            ovr_set;
   logic            perr_set;
   logic            valid_d;
   logic            perr_q;

   // Parity of the data held in sr plus the incoming parity bit.
   assign par_check = ((^sr_q) ^ Shift_In) != PARITY_ODD;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      word      = sr_q;
      if (Sync) begin
         state_d = S_RECV;
         sr_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_RECV: begin
               if (Shift_En) begin
                  sr_d = {Shift_In, sr_q[SIZE-1:1]};
                  if (cnt_q == LAST) begin
`ifdef DESERIALIZER_PARITY_EN
                     state_d = S_PARITY;
                     cnt_d   = cnt_q + 1'b1;
`else
                     word_done = 1'b1;
                     word      = {Shift_In, sr_q[SIZE-1:1]};
                     cnt_d     = '0;
`endif
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
`ifdef DESERIALIZER_PARITY_EN
            S_PARITY: begin
               if (Shift_En) begin
                  word_done = 1'b1;
                  word      = sr_q;
                  state_d   = S_RECV;
                  cnt_d     = '0;
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign load     = word_done && (!Data_Valid || Data_Ack);
   assign ovr_set  = word_done && Data_Valid && !Data_Ack;
   assign perr_set = PAR_EN && word_done && par_check;

   always_comb begin
      valid_d = Data_Valid;
      if (load)
         valid_d = 1'b1;
      else if (Data_Valid && Data_Ack)
         valid_d = 1'b0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Set events beat a simultaneous Clr_Err on the sticky flags.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Data_Out   <= '0;
         Data_Valid <= 1'b0;
         Overrun    <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         if (load)
            Data_Out <= word;
         Data_Valid <= valid_d;
         if (ovr_set)
            Overrun <= 1'b1;
         else if (Clr_Err)
            Overrun <= 1'b0;
         if (perr_set)
            perr_q <= 1'b1;
         else if (Clr_Err)
            perr_q <= 1'b0;
      end
   end

   assign Parity_Err = perr_q;
   assign Bit_Count  = cnt_q;
   assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: a queue-based receive model checked every cycle,
// plus literal expectations; define DESERIALIZER_PARITY_EN to exercise the parity build.
module tb_serial_deserializer;

   localparam int SIZE       = 8;
   localparam bit PARITY_ODD = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            Sync, Shift_En, Shift_In, Data_Ack, Clr_Err;
   logic [SIZE-1:0] Data_Out;
   logic            Data_Valid, Overrun, Parity_Err, Busy;
   logic [3:0]      Bit_Count;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   serial_deserializer #(.SIZE(SIZE), .PARITY_ODD(PARITY_ODD)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Sync(Sync), .Shift_En(Shift_En),
      .Shift_In(Shift_In), .Data_Ack(Data_Ack), .Clr_Err(Clr_Err),
      .Data_Out(Data_Out), .Data_Valid(Data_Valid), .Overrun(Overrun),
      .Parity_Err(Parity_Err), .Bit_Count(Bit_Count), .Busy(Busy)
   );

   // clock / reset
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: collect bits into a queue, deliver when a frame is full
   bit              m_busy;
   bit              m_bits[$];
   logic [SIZE-1:0] m_out;
   bit              m_valid, m_ovr, m_perr;
   logic [SIZE-1:0] m_w;
   bit              m_deliver, m_oset, m_pset;
   int              m_ones;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_busy = 0; m_bits.delete(); m_out = '0;
         m_valid = 0; m_ovr = 0; m_perr = 0;
      end else begin
         m_deliver = 0; m_oset = 0; m_pset = 0;
         if (Sync) begin
            m_busy = 1;
            m_bits.delete();
         end else if (m_busy && Shift_En) begin
            m_bits.push_back(Shift_In);
            if (m_bits.size() == SIZE + PBITS) begin
               m_ones = 0;
               for (int i = 0; i < SIZE; i++) m_w[i] = m_bits[i];
               for (int i = 0; i < SIZE + PBITS; i++) m_ones += int'(m_bits[i]);
               m_pset    = (PBITS == 1) && ((m_ones % 2) != int'(PARITY_ODD));
               m_deliver = 1;
               m_bits.delete();
            end
         end
         if (m_deliver) begin
            if (m_valid && !Data_Ack) m_oset = 1;
            else begin m_out = m_w; m_valid = 1; end
         end else if (m_valid && Data_Ack) begin
            m_valid = 0;
         end
         if (m_oset) m_ovr = 1; else if (Clr_Err) m_ovr = 0;
         if (m_pset) m_perr = 1; else if (Clr_Err) m_perr = 0;
      end
   end

   // scoreboard: every cycle, away from the active edge
   always @(negedge Clk) begin
      if (cmp_en) begin
         check("data_out",   Data_Out,   m_out);
         check("data_valid", Data_Valid, m_valid);
         check("overrun",    Overrun,    m_ovr);
         check("parity_err", Parity_Err, m_perr);
         check("bit_count",  Bit_Count,  m_bits.size());
         check("busy",       Busy,       m_busy);
      end
   end

   // driver tasks: start and end on a falling edge
   task automatic send_bit(input logic b, input logic ack);
      Shift_En = 1'b1; Shift_In = b; Data_Ack = ack;
      @(negedge Clk);
      Shift_En = 1'b0; Shift_In = 1'b0; Data_Ack = 1'b0;
   endtask

   task automatic send_word(input logic [SIZE-1:0] w, input logic ack_last);
      for (int i = 0; i < SIZE; i++)
         send_bit(w[i], ack_last && (i == SIZE - 1) && (PBITS == 0));
      if (PBITS == 1) send_bit((^w) ^ PARITY_ODD, ack_last);
   endtask

   task automatic sync_pulse(input logic en, input logic b);
      Sync = 1'b1; Shift_En = en; Shift_In = b;
      @(negedge Clk);
      Sync = 1'b0; Shift_En = 1'b0; Shift_In = 1'b0;
   endtask

   task automatic ack_pulse();
      Data_Ack = 1'b1;
      @(negedge Clk);
      Data_Ack = 1'b0;
   endtask

   task automatic clr_pulse();
      Clr_Err = 1'b1;
      @(negedge Clk);
      Clr_Err = 1'b0;
   endtask

   logic [SIZE-1:0] pats [3];

   initial begin
      Reset_n = 1'b0; Sync = 0; Shift_En = 0; Shift_In = 0; Data_Ack = 0; Clr_Err = 0;
      repeat (2) @(negedge Clk);
      check("rst_data_out", Data_Out, 0);
      check("rst_valid", Data_Valid, 0);
      check("rst_bit_count", Bit_Count, 0);
      check("rst_busy", Busy, 0);
      Reset_n = 1'b1;
      cmp_en  = 1'b1;

      // strobes in IDLE are ignored
      send_bit(1'b1, 1'b0);
      check("idle_bit_count", Bit_Count, 0);

      // A5: bits 1,0,1,0,0,1,0,1
      sync_pulse(1'b0, 1'b0);
      check("sync_busy", Busy, 1);
      send_word(8'hA5, 1'b0);
      check("a5_data", Data_Out, 8'hA5);
      check("a5_valid", Data_Valid, 1);
      ack_pulse();
      check("a5_acked", Data_Valid, 0);

      // overrun: 3C then 81 without ack
      send_word(8'h3C, 1'b0);
      send_word(8'h81, 1'b0);
      check("ovr_data", Data_Out, 8'h3C);
      check("ovr_flag", Overrun, 1);
      clr_pulse();
      check("ovr_cleared", Overrun, 0);
      ack_pulse();

      // ack on the completing edge of the second word
      send_word(8'h3C, 1'b0);
      send_word(8'h81, 1'b1);
      check("ackc_data", Data_Out, 8'h81);
      check("ackc_valid", Data_Valid, 1);
      check("ackc_ovr", Overrun, 0);
      ack_pulse();

      // 3 stray bits, Sync with a strobe, then FF
      send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
      check("partial_count", Bit_Count, 3);
      sync_pulse(1'b1, 1'b0);
      check("sync_count", Bit_Count, 0);
      send_word(8'hFF, 1'b0);
      check("ff_data", Data_Out, 8'hFF);

      // asynchronous reset mid-word with a valid word held
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      check("pre_rst_count", Bit_Count, 5);
      check("pre_rst_valid", Data_Valid, 1);
      #2 Reset_n = 1'b0;
      #1;
      check("arst_data", Data_Out, 0);
      check("arst_valid", Data_Valid, 0);
      check("arst_count", Bit_Count, 0);
      check("arst_busy", Busy, 0);
      check("arst_ovr", Overrun, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      check("post_rst_count", Bit_Count, 0);
      check("post_rst_busy", Busy, 0);

      // a few more directed words, each acknowledged
      sync_pulse(1'b0, 1'b0);
      pats[0] = 8'h00; pats[1] = 8'h5A; pats[2] = 8'hC3;
      for (int i = 0; i < 3; i++) begin
         send_word(pats[i], 1'b0);
         check("pat_data", Data_Out, pats[i]);
         ack_pulse();
      end

`ifdef DESERIALIZER_PARITY_EN
      for (int i = 0; i < SIZE; i++) send_bit(i < 3, 1'b0);
      check("par_hold_count", Bit_Count, SIZE);
      send_bit(1'b1, 1'b0);
      check("par_good", Parity_Err, 0);
      check("par_good_data", Data_Out, 8'h07);
      ack_pulse();
      for (int i = 0; i < SIZE; i++) send_bit(i < 3, 1'b0);
      send_bit(1'b0, 1'b0);
      check("par_bad", Parity_Err, 1);
      check("par_bad_data", Data_Out, 8'h07);
      clr_pulse();
      check("par_cleared", Parity_Err, 0);
      ack_pulse();
`endif

      repeat (2) @(negedge Clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
